// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron trainer: sizes, FSM encoding and
// the saturating weight-step arithmetic.
package perceptron_pkg;

    localparam int W_W   = 32;
    localparam int N_IN  = 8;
    localparam int BUS_W = W_W * N_IN;

    localparam logic [31:0] W_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] W_MIN = 32'h8000_0000;

    // Signed limits widened so a +/- step of any 32-bit rate cannot overflow.
    localparam logic signed [33:0] SAT_MAX_X = 34'sh0_7FFF_FFFF;
    localparam logic signed [33:0] SAT_MIN_X = 34'sh3_8000_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        EVAL   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Signed weight plus/minus an unsigned rate, clamped to the signed range.
    function automatic logic [31:0] sat_addsub(input logic [31:0] a,
                                               input logic [31:0] rate,
                                               input logic        sub);
        logic signed [33:0] a_x;
        logic signed [33:0] r_x;
        logic signed [33:0] s_x;
        logic [31:0]        res;
        a_x = {{2{a[31]}}, a};
        r_x = {2'b00, rate};
        s_x = sub ? (a_x - r_x) : (a_x + r_x);
        if (s_x > SAT_MAX_X)
            res = W_MAX;
        else if (s_x < SAT_MIN_X)
            res = W_MIN;
        else
            res = s_x[31:0];
        return res;
    endfunction

endpackage

// File: rtl/perceptron_trainer_sat_addsub32.sv
// Signed 32-bit saturating add/subtract of the fixed learning rate.
module sat_addsub32
    import perceptron_pkg::*;
#(
    parameter logic [31:0] RATE = 32'd1
) (
    input  logic [31:0] a,
    input  logic        sub,
    output logic [31:0] y
);

    // Pure combinational step; the caller decides whether to use it.
    assign y = sat_addsub(a, RATE, sub);

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training step: waits for the external weighted sum, compares
// against the threshold, and on a wrong prediction nudges each active weight
// one per cycle.
//
// state  | meaning
// IDLE   | waiting for start or w_load
// WAIT   | down-counting the weighted_sum latency
// EVAL   | sampling sum, deciding match/mismatch
// UPDATE | adjusting weight idx (0..7), one per cycle
// DONE   | one-cycle completion pulse
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int unsigned        SUM_LAT   = 1,
    parameter logic [31:0]        RATE      = 32'd1,
    parameter logic signed [31:0] THRESHOLD = 32'sd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_IN-1:0]     x,
    input  logic                target,
    input  logic signed [31:0]  sum,
    input  logic                w_load,
    input  logic [BUS_W-1:0]    w_in,
    output logic [BUS_W-1:0]    w,
    output logic                busy,
    output logic                done,
    output logic                mismatch,
    output logic [15:0]         err_count
);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      wcnt;
    logic [2:0]      idx;
    logic [N_IN-1:0] x_q;
    logic            tgt_q;
    logic            y;
    logic [31:0]     w_cur;
    logic [31:0]     w_upd;

    assign y     = (sum > THRESHOLD);
    assign w_cur = w[{idx, 5'd0} +: 32];

    sat_addsub32 #(.RATE(RATE)) u_step (
        .a   (w_cur),
        .sub (~tgt_q),
        .y   (w_upd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (wcnt <= 4'd1) state_nxt = EVAL;
            EVAL:    state_nxt = (y == tgt_q) ? DONE : UPDATE;
            UPDATE:  if (idx == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Captured inputs, latency timer, weight bank and error statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            tgt_q     <= 1'b0;
            wcnt      <= 4'd0;
            idx       <= 3'd0;
            w         <= '0;
            mismatch  <= 1'b0;
            err_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q   <= x;
                        tgt_q <= target;
                        wcnt  <= 4'(SUM_LAT);
                    end else if (w_load) begin
                        w <= w_in;
                    end
                end
                WAIT: wcnt <= wcnt - 4'd1;
                EVAL: begin
                    mismatch <= (y != tgt_q);
                    idx      <= 3'd0;
                    if ((y != tgt_q) && (err_count != 16'hFFFF))
                        err_count <= err_count + 16'd1;
                end
                UPDATE: begin
                    if (x_q[idx])
                        w[{idx, 5'd0} +: 32] <= w_upd;
                    idx <= idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Randomised self-checking bench for perceptron_trainer with a behavioural
// weighted_sum model on the sum input and an arithmetic reference model.
module tb_perceptron_trainer;

    localparam int unsigned        SUM_LAT   = 3;
    localparam logic [31:0]        RATE      = 32'd1;
    localparam logic signed [31:0] THRESHOLD = 32'sd0;

    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         x;
    logic               target;
    logic signed [31:0] sum;
    logic               w_load;
    logic [255:0]       w_in;
    logic [255:0]       w;
    logic               busy;
    logic               done;
    logic               mismatch;
    logic [15:0]        err_count;

    // weighted_sum environment: uses the step's x, optionally overridden.
    logic [7:0]         x_sum;
    logic               force_en;
    logic signed [31:0] force_val;

    int n_tests;
    int n_fail;

    logic [31:0] mw [8];
    int          merr;

    perceptron_trainer #(
        .SUM_LAT   (SUM_LAT),
        .RATE      (RATE),
        .THRESHOLD (THRESHOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x         (x),
        .target    (target),
        .sum       (sum),
        .w_load    (w_load),
        .w_in      (w_in),
        .w         (w),
        .busy      (busy),
        .done      (done),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        sum = 32'sd0;
        for (int i = 0; i < 8; i++)
            if (x_sum[i]) sum = sum + $signed(w[i*32 +: 32]);
        if (force_en) sum = force_val;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pack_w();
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = mw[i];
        return p;
    endfunction

    function automatic logic [31:0] sat_ref(input logic [31:0] a, input logic up);
        longint v;
        v = longint'($signed(a));
        v = up ? v + longint'(RATE) : v - longint'(RATE);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    task automatic load_w(input logic [255:0] v);
        w_load = 1'b1;
        w_in   = v;
        @(posedge clk); #1;
        w_load = 1'b0;
        for (int i = 0; i < 8; i++) mw[i] = v[i*32 +: 32];
    endtask

    task automatic do_step(input logic [7:0] xv, input logic tv, input bit noise,
                           input bit frc, input logic signed [31:0] fval, input string tag);
        logic signed [31:0] s;
        bit                 mis;
        int                 lat;
        int                 exp_lat;
        logic               got_mis;
        logic [255:0]       w_before;
        s = 32'sd0;
        for (int i = 0; i < 8; i++) if (xv[i]) s = s + $signed(mw[i]);
        if (frc) s = fval;
        mis      = ((s > THRESHOLD) != tv);
        exp_lat  = mis ? int'(SUM_LAT) + 10 : int'(SUM_LAT) + 2;
        w_before = pack_w();
        x_sum     = xv;
        force_en  = frc;
        force_val = fval;
        x         = xv;
        target    = tv;
        start     = 1'b1;
        lat       = 0;
        got_mis   = 1'b0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            start  = 1'b0;
            w_load = 1'b0;
            if (done) begin
                lat     = n;
                got_mis = mismatch;
            end else begin
                if (n == int'(SUM_LAT) + 1) check({tag, " w_stable"}, w, w_before);
                if (noise && $urandom_range(0, 3) == 0) begin
                    start  = 1'b1;
                    x      = 8'($urandom);
                    target = 1'($urandom);
                end
                if (noise && $urandom_range(0, 3) == 0) begin
                    w_load = 1'b1;
                    for (int i = 0; i < 8; i++) w_in[i*32 +: 32] = $urandom;
                end
            end
        end
        start  = 1'b0;
        w_load = 1'b0;
        if (mis) begin
            if (merr != 65535) merr++;
            for (int i = 0; i < 8; i++) if (xv[i]) mw[i] = sat_ref(mw[i], tv);
        end
        check({tag, " latency"}, 256'(lat), 256'(exp_lat));
        check({tag, " mismatch"}, 256'(got_mis), 256'(mis));
        check({tag, " w"}, w, pack_w());
        check({tag, " err_count"}, 256'(err_count), 256'(merr));
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 256'({done, busy}), 256'(0));
        force_en = 1'b0;
    endtask

    initial begin
        logic [255:0] v;
        bit           seen_done;
        n_tests   = 0;
        n_fail    = 0;
        merr      = 0;
        rst       = 1'b1;
        start     = 1'b0;
        x         = '0;
        target    = 1'b0;
        w_load    = 1'b0;
        w_in      = '0;
        x_sum     = '0;
        force_en  = 1'b0;
        force_val = '0;
        for (int i = 0; i < 8; i++) mw[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset w", w, 256'd0);
        check("reset flags", 256'({busy, done, mismatch}), 256'(0));
        check("reset err_count", 256'(err_count), 256'(0));

        load_w({8{32'd5}});
        check("preload w", w, {8{32'd5}});
        check("preload busy", 256'(busy), 256'(0));
        check("preload err_count", 256'(err_count), 256'(0));

        load_w('0);
        do_step(8'h03, 1'b1, 1'b0, 1'b0, 32'sd0, "zero_w_miss");
        check("zero_w_miss explicit w", w, {192'd0, 32'd1, 32'd1});

        load_w({224'd0, 32'd10});
        do_step(8'h01, 1'b1, 1'b0, 1'b0, 32'sd0, "match");
        check("match explicit err", 256'(err_count), 256'(1));

        load_w({32'h7FFF_FFFF, 224'd0});
        do_step(8'h80, 1'b1, 1'b0, 1'b1, -32'sd1, "sat_hi");
        check("sat_hi explicit w7", 256'(w[255:224]), 256'(32'h7FFF_FFFF));

        load_w({32'h8000_0000, 224'd0});
        do_step(8'h80, 1'b0, 1'b0, 1'b1, 32'sd5, "sat_lo");
        check("sat_lo explicit w7", 256'(w[255:224]), 256'(32'h8000_0000));

        w_in   = {8{32'hDEAD_0000}};
        w_load = 1'b1;
        do_step(8'h01, 1'b0, 1'b0, 1'b0, 32'sd0, "start_over_load");

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < 8; i++) begin
                    if ($urandom_range(0, 5) == 0)
                        v[i*32 +: 32] = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFE : 32'h8000_0001;
                    else
                        v[i*32 +: 32] = 32'($urandom_range(0, 40)) - 32'd20;
                end
                load_w(v);
            end
            do_step(8'($urandom), 1'($urandom), 1'b1, 1'b0, 32'sd0, $sformatf("rand%0d", k));
        end

        load_w('0);
        x_sum     = 8'hFF;
        x         = 8'hFF;
        target    = 1'b1;
        start     = 1'b1;
        seen_done = 1'b0;
        for (int n = 1; n <= int'(SUM_LAT) + 14; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst   = 1'b0;
            if (done) seen_done = 1'b1;
            if (n == int'(SUM_LAT) + 3) begin
                start = 1'b1;
                x     = 8'h0F;
            end
            if (n == int'(SUM_LAT) + 6) begin
                check("abort partial w", w, {128'd0, {4{32'd1}}});
                rst = 1'b1;
            end
            if (n == int'(SUM_LAT) + 7) begin
                check("abort w cleared", w, 256'd0);
                check("abort idle", 256'({busy, mismatch}), 256'(0));
                check("abort err_count", 256'(err_count), 256'(0));
            end
        end
        check("abort stays idle", 256'(busy), 256'(0));
        check("abort no done", 256'(seen_done), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 Parameter SUM_LAT, default 1, meaning cycles from start accepted to sum sampled (1..15).
REQ-002 Parameter RATE, default 1, meaning unsigned learning increment applied per weight update.
REQ-003 Parameter THRESHOLD, default 0, meaning signed 32-bit activation threshold.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to train on current x/target; honoured only in IDLE.
REQ-007 x  input  8  binary input vector, captured on accepted start.
REQ-008 target  input  1  desired perceptron output, captured on accepted start.
REQ-009 sum  input  32  signed weighted sum returned by the weighted_sum block driven from w.
REQ-010 w_load  input  1  load w_in into weight register; honoured only in IDLE, lower priority than start.
REQ-011 w_in  input  256  preload weights, same packing as w.
REQ-012 w  output  256  registered weight bus to weighted_sum; weight i (signed 32-bit) at bits 32*i+31:32*i.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a training step completes.
REQ-015 mismatch  output  1  registered; valid with done; 1 if prediction differed from target.
REQ-016 err_count  output  16  number of mismatching steps since reset, saturating at 16'hFFFF.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, EVAL, UPDATE, DONE.
REQ-018 IDLE + start: capture x, target; load wait counter with SUM_LAT; go WAIT; w_load same cycle ignored.
REQ-019 IDLE + w_load, no start: w <= w_in next edge; stay IDLE.
REQ-020 WAIT decrements counter each cycle; at counter 1 go EVAL, so sum is sampled exactly SUM_LAT+1 cycles after start edge.
REQ-021 EVAL computes y = (signed sum > signed THRESHOLD); y == target -> DONE with mismatch=0; else UPDATE with mismatch=1, err_count+1 (saturating), index cleared to 0.
REQ-022 UPDATE processes one weight per cycle, index 0..7; after index 7 go DONE; UPDATE always lasts exactly 8 cycles.
REQ-023 Per weight i with captured x[i]=1: target=1 -> w_i + RATE; target=0 -> w_i - RATE; x[i]=0 -> unchanged.
REQ-024 Weight arithmetic SHALL saturate at signed limits 32'h7FFFFFFF and 32'h80000000; no wrap-around.
REQ-025 DONE lasts one cycle, asserts done, returns to IDLE; start in DONE is ignored.
REQ-026 start and w_load outside IDLE SHALL be ignored with no side effect.
REQ-027 Total step latency: start to done = SUM_LAT+2 cycles on match, SUM_LAT+10 on mismatch.
REQ-028 w SHALL change only in UPDATE or on honoured w_load; stable during WAIT/EVAL.

Reset
REQ-029 rst high at clock edge: state IDLE, w=0, busy=0, done=0, mismatch=0, err_count=0, counters/index=0.
REQ-030 rst mid-operation aborts the step; partial updates discarded by w clearing; rst priority over all inputs.

Structure
REQ-031 State encoding, weight width (32), input count (8), and saturating add/sub helper belong in shared package perceptron_pkg.
REQ-032 One sub-module natural: sat_addsub32 (signed 32-bit saturating add/subtract of RATE).
REQ-033 weighted_sum is not instantiated inside; bench connects w->weighted_sum->sum.

Verification
REQ-034 Reset then w_load w_in={8{32'd5}} -> w==that bus, busy=0, err_count=0.
REQ-035 w=0, x=8'h03, target=1 (sum=0, not >0) -> mismatch=1, weights 0,1 become 1, others 0, done at SUM_LAT+10.
REQ-036 w_0=10, x=8'h01, target=1 (sum=10) -> mismatch=0, w unchanged, done at SUM_LAT+2, err_count unchanged.
REQ-037 w_7=32'h7FFFFFFF, x=8'h80, target=1, forced sum=-1 -> w_7 stays 32'h7FFFFFFF; w_7=32'h80000000, target=0, sum=5 -> stays 32'h80000000.
REQ-038 start pulsed during UPDATE and rst asserted at UPDATE index 4 -> second start ignored; after rst w=0, state IDLE, done never pulses.
REQ-039 w_load and start same IDLE cycle -> start taken, w unchanged by w_in.
